// File: rtl/kf_step_ctrl_pkg.sv
// Shared constants for the Kalman step controller: word widths, FSM state
// encodings, stage indices and small helpers used by the controller.
package kf_step_ctrl_pkg;

    // Fixed-point format shared with the serial datapath stages.
    localparam int FXP_N    = 16;
    localparam int FXP_FRAC = 8;

    // Watchdog defaults.
    localparam int KF_TIMEOUT_DEFAULT = 255;
    localparam int KF_TW_DEFAULT      = 8;

    // Controller FSM state encodings.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    // Datapath stage indices, also the bit positions in stg_start/stg_done.
    localparam logic [1:0] STG_PRIOR_X = 2'd0;
    localparam logic [1:0] STG_PRIOR_P = 2'd1;
    localparam logic [1:0] STG_GAIN    = 2'd2;
    localparam logic [1:0] STG_UPDATE  = 2'd3;

    // One-hot start vector for stage k.
    function automatic logic [3:0] stage_onehot(input logic [1:0] k);
        stage_onehot = 4'b0001 << k;
    endfunction

    // Stage that follows k in the iteration; the update stage is terminal.
    function automatic logic [1:0] next_stage(input logic [1:0] k);
        unique case (k)
            STG_PRIOR_X: next_stage = STG_PRIOR_P;
            STG_PRIOR_P: next_stage = STG_GAIN;
            STG_GAIN:    next_stage = STG_UPDATE;
            default:     next_stage = STG_UPDATE;
        endcase
    endfunction

endpackage

// File: rtl/kf_stage_watchdog.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th enabled cycle is being spent.
module kf_stage_watchdog #(
    parameter int TW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    // Count value seen during the TIMEOUT-th enabled cycle.
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_cnt;

    // Cycle counter; saturates at LIMIT so expire stays asserted if ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/kf_step_ctrl.sv
// Kalman iteration sequencer: accepts a step request, runs the four datapath
// stages through start/done handshakes with a per-stage watchdog, and commits
// the posterior into the filter state registers it owns.
module kf_step_ctrl
    import kf_step_ctrl_pkg::*;
#(
    parameter int N       = FXP_N,
    parameter int FRAC    = FXP_FRAC,
    parameter int TIMEOUT = KF_TIMEOUT_DEFAULT,
    parameter int TW      = KF_TW_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_init,
    input  logic [N-1:0] i_x0_init,
    input  logic [N-1:0] i_x1_init,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [N-1:0] i_u0_in,
    input  logic [N-1:0] i_u1_in,
    input  logic [N-1:0] i_z_in,
    output logic [N-1:0] o_u00,
    output logic [N-1:0] o_u10,
    output logic [N-1:0] o_z00,
    output logic [N-1:0] o_x00,
    output logic [N-1:0] o_x10,
    output logic [3:0]   o_stg_start,
    input  logic [3:0]   i_stg_done,
    input  logic [N-1:0] i_xpost0_in,
    input  logic [N-1:0] i_xpost1_in,
    output logic         o_out_valid,
    output logic         o_busy,
    output logic         o_err,
    output logic [1:0]   o_err_stage,
    input  logic         i_clr_err
);

    // FRAC only describes the format of the values passed through.
    if ((TIMEOUT < 1) || (TIMEOUT > (2 ** TW) - 1) || (FRAC > N)) begin : g_bad_param
        $error("kf_step_ctrl: TIMEOUT must be 1..2^TW-1 and FRAC <= N");
    end

    logic [2:0]   r_state;
    logic [2:0]   w_state_d;
    logic [1:0]   r_k;
    logic [1:0]   w_k_d;
    logic [N-1:0] r_x0;
    logic [N-1:0] r_x1;
    logic [N-1:0] r_u0;
    logic [N-1:0] r_u1;
    logic [N-1:0] r_z;
    logic [1:0]   r_err_stage;

    logic w_done;
    logic w_expire;
    logic w_accept;
    logic w_load_init;
    logic w_commit_load;
    logic w_fault_entry;

    // Only the done bit of the stage currently running is meaningful.
    assign w_done        = i_stg_done[r_k];
    assign w_accept      = o_req_ready && i_req_valid;
    assign w_load_init   = (r_state == ST_IDLE) && i_init;
    assign w_commit_load = (r_state == ST_WAIT) && w_done && (r_k == STG_UPDATE);
    assign w_fault_entry = (r_state == ST_WAIT) && !w_done && w_expire;

    kf_stage_watchdog #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (r_state == ST_START),
        .i_en     (r_state == ST_WAIT),
        .o_expire (w_expire)
    );

    // Next-state and stage-index decode; done beats a coinciding timeout.
    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = ST_START;
                    w_k_d     = STG_PRIOR_X;
                end
            end
            ST_START: begin
                w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done) begin
                    if (r_k == STG_UPDATE) begin
                        w_state_d = ST_COMMIT;
                    end else begin
                        w_k_d     = next_stage(r_k);
                        w_state_d = ST_START;
                    end
                end else if (w_expire) begin
                    w_state_d = ST_FAULT;
                end
            end
            ST_COMMIT: begin
                w_state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (i_clr_err) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and stage index registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_k     <= STG_PRIOR_X;
        end else begin
            r_state <= w_state_d;
            r_k     <= w_k_d;
        end
    end

    // Filter state, latched request operands and fault stage capture.
    // The posterior is taken on the edge into COMMIT so x is new while out_valid is high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x0        <= '0;
            r_x1        <= '0;
            r_u0        <= '0;
            r_u1        <= '0;
            r_z         <= '0;
            r_err_stage <= '0;
        end else begin
            if (w_load_init) begin
                r_x0 <= i_x0_init;
                r_x1 <= i_x1_init;
            end else if (w_commit_load) begin
                r_x0 <= i_xpost0_in;
                r_x1 <= i_xpost1_in;
            end
            if (w_accept) begin
                r_u0 <= i_u0_in;
                r_u1 <= i_u1_in;
                r_z  <= i_z_in;
            end
            if (w_fault_entry) begin
                r_err_stage <= r_k;
            end
        end
    end

    assign o_req_ready = (r_state == ST_IDLE) && !i_init;
    assign o_stg_start = (r_state == ST_START) ? stage_onehot(r_k) : 4'b0000;
    assign o_out_valid = (r_state == ST_COMMIT);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_err       = (r_state == ST_FAULT);
    assign o_err_stage = r_err_stage;
    assign o_x00       = r_x0;
    assign o_x10       = r_x1;
    assign o_u00       = r_u0;
    assign o_u10       = r_u1;
    assign o_z00       = r_z;

endmodule

// File: tb/tb_kf_step_ctrl.sv
// Self-checking bench for kf_step_ctrl: stub datapath stages with programmable
// latencies, a timeline model of the step schedule, and directed scenarios.
module tb_kf_step_ctrl;
    import kf_step_ctrl_pkg::*;

    localparam int N  = 16;
    localparam int TO = 8;
    localparam int TW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         init = 1'b0;
    logic [N-1:0] x0_init = '0;
    logic [N-1:0] x1_init = '0;
    logic         req_valid = 1'b0;
    logic [N-1:0] u0 = '0;
    logic [N-1:0] u1 = '0;
    logic [N-1:0] z = '0;
    logic         clr_err = 1'b0;
    logic [N-1:0] xpost0 = '0;
    logic [N-1:0] xpost1 = '0;
    logic [3:0]   stub_done = '0;
    logic [3:0]   spur_done = '0;
    logic [3:0]   stg_done;
    assign stg_done = stub_done | spur_done;

    logic         o_req_ready;
    logic [N-1:0] o_u00, o_u10, o_z00, o_x00, o_x10;
    logic [3:0]   o_stg_start;
    logic         o_out_valid, o_busy, o_err;
    logic [1:0]   o_err_stage;

    kf_step_ctrl #(
        .N       (N),
        .FRAC    (8),
        .TIMEOUT (TO),
        .TW      (TW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_init      (init),
        .i_x0_init   (x0_init),
        .i_x1_init   (x1_init),
        .i_req_valid (req_valid),
        .o_req_ready (o_req_ready),
        .i_u0_in     (u0),
        .i_u1_in     (u1),
        .i_z_in      (z),
        .o_u00       (o_u00),
        .o_u10       (o_u10),
        .o_z00       (o_z00),
        .o_x00       (o_x00),
        .o_x10       (o_x10),
        .o_stg_start (o_stg_start),
        .i_stg_done  (stg_done),
        .i_xpost0_in (xpost0),
        .i_xpost1_in (xpost1),
        .o_out_valid (o_out_valid),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_err_stage (o_err_stage),
        .i_clr_err   (clr_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Stub stages: stage k raises done in the L-th cycle after its start pulse
    // (L = 0 means the stage never finishes).
    int stub_L[4] = '{1, 1, 1, 1};
    int st_cyc[4] = '{-100000, -100000, -100000, -100000};
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (o_stg_start[k]) st_cyc[k] = cyc;
            end
            for (int k = 0; k < 4; k++) begin
                stub_done[k] = (stub_L[k] > 0) && (cyc == st_cyc[k] + stub_L[k]);
            end
        end
    end

    // Timeline model: on acceptance, the start offsets of every stage, the
    // commit offset and any fault offset follow from the stub latencies.
    bit           m_valid = 0;
    int           m_mode  = 0;    // 0 idle, 1 stepping, 2 fault
    int           m_acc, m_sc, m_fault_at, m_fstage;
    int           m_s[4];
    logic [N-1:0] m_x0, m_x1, m_u0, m_u1, m_z, m_p0, m_p1;
    logic [1:0]   m_es;

    initial begin
        int         o;
        logic [3:0] e_start;
        logic       e_ov;
        forever begin
            @(negedge clk);
            o = cyc - m_acc;
            if (m_valid) begin
                e_start = '0;
                e_ov    = 1'b0;
                if (m_mode == 1) begin
                    for (int k = 0; k < 4; k++) if (m_s[k] == o) e_start[k] = 1'b1;
                    e_ov = (o == m_sc);
                end
                chk("req_ready", o_req_ready, (m_mode == 0) && !init);
                chk("busy", o_busy, m_mode != 0);
                chk("err", o_err, m_mode == 2);
                chk("err_stage", o_err_stage, m_es);
                chk("stg_start", o_stg_start, e_start);
                chk("out_valid", o_out_valid, e_ov);
                chk("x00", o_x00, m_x0);
                chk("x10", o_x10, m_x1);
                chk("u00", o_u00, m_u0);
                chk("u10", o_u10, m_u1);
                chk("z00", o_z00, m_z);
            end
            if (rst) begin
                m_valid = 1; m_mode = 0; m_es = '0;
                m_x0 = '0; m_x1 = '0; m_u0 = '0; m_u1 = '0; m_z = '0;
            end else if (m_valid) begin
                if (m_mode == 0) begin
                    if (init) begin
                        m_x0 = x0_init; m_x1 = x1_init;
                    end else if (req_valid) begin
                        m_u0 = u0; m_u1 = u1; m_z = z; m_p0 = xpost0; m_p1 = xpost1;
                        m_acc = cyc; m_mode = 1; m_fault_at = -1; m_sc = -1;
                        m_s = '{-1, -1, -1, -1};
                        for (int k = 0; k < 4; k++) begin
                            m_s[k] = (k == 0) ? 1 : m_s[k-1] + 1 + stub_L[k-1];
                            if (stub_L[k] == 0 || stub_L[k] > TO) begin
                                m_fault_at = m_s[k] + TO; m_fstage = k;
                                break;
                            end
                            if (k == 3) m_sc = m_s[3] + 1 + stub_L[3];
                        end
                    end
                end else if (m_mode == 1) begin
                    if (m_sc >= 0 && o == m_sc - 1) begin
                        m_x0 = m_p0; m_x1 = m_p1;
                    end
                    if (o == m_sc) m_mode = 0;
                    if (m_fault_at >= 0 && o == m_fault_at) begin
                        m_mode = 2; m_es = 2'(m_fstage);
                    end
                end else if (clr_err) begin
                    m_mode = 0;
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Issue a request in the current cycle; return its acceptance cycle.
    task automatic do_req(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] c, output int acc);
        req_valid = 1'b1; u0 = a; u1 = b; z = c;
        @(negedge clk);
        acc = cyc;
        chk("req_accept_ready", o_req_ready, 1);
        next();
        req_valid = 1'b0; u0 = ~a; u1 = ~b; z = ~c;
    endtask

    task automatic wait_ov(input string name, input int budget, output int at, output bit saw_err);
        at = -1; saw_err = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_err) saw_err = 1;
            if (o_out_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk(name, 0, 1);
    endtask

    initial begin
        int acc, at, commits;
        bit saw;
        int ovc[3] = '{0, 0, 0};

        repeat (3) next();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", o_req_ready, 1);
        chk("reset_x00", o_x00, 0);
        next();

        // Nominal step: x = [1.0, -0.5], u = [0.25, 0], z = 0.
        init = 1'b1; x0_init = 16'd256; x1_init = 16'hFF80;
        next();
        init = 1'b0;
        stub_L = '{3, 5, 7, 2}; xpost0 = 16'd160; xpost1 = 16'hFFC0;
        do_req(16'd64, 16'd0, 16'd0, acc);
        wait_ov("nom_ov_timeout", 60, at, saw);
        chk("nom_latency", at - acc, 22);
        chk("nom_x00", o_x00, 16'h00A0);
        chk("nom_x10", o_x10, 16'hFFC0);
        chk("nom_start0", st_cyc[0] - acc, 1);
        chk("nom_start1", st_cyc[1] - st_cyc[0], 4);
        chk("nom_start2", st_cyc[2] - st_cyc[1], 6);
        chk("nom_start3", st_cyc[3] - st_cyc[2], 8);
        next();

        // Back-to-back: request held high, operands changing every cycle.
        stub_L = '{1, 1, 1, 1}; xpost0 = 16'h0011; xpost1 = 16'h0022;
        req_valid = 1'b1; commits = 0;
        for (int i = 0; i < 60 && commits < 3; i++) begin
            @(negedge clk);
            if (o_out_valid) begin
                ovc[commits] = cyc;
                commits++;
            end
            next();
            if (commits == 3) req_valid = 1'b0;
            u0 = 16'(cyc * 3); u1 = 16'(cyc * 5 + 1); z = 16'(cyc ^ 32'h5a5a);
        end
        chk("b2b_count", commits, 3);
        chk("b2b_gap1", ovc[1] - ovc[0], 10);
        chk("b2b_gap2", ovc[2] - ovc[1], 10);
        next();

        // Timeout in the gain stage; requests and init ignored while faulted.
        stub_L = '{2, 2, 0, 2};
        do_req(16'd5, 16'd6, 16'd7, acc);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_err) begin
                at = cyc;
                break;
            end
        end
        chk("to_err_cycle", at - acc, 16);
        chk("to_err_stage", o_err_stage, 32'(STG_GAIN));
        chk("to_x00_kept", o_x00, 16'h0011);
        next();
        req_valid = 1'b1; init = 1'b1; x0_init = 16'h7777;
        repeat (3) next();
        req_valid = 1'b0; init = 1'b0; clr_err = 1'b1;
        next();
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_ready", o_req_ready, 1);
        chk("clr_err_low", o_err, 0);
        next();
        stub_L = '{3, 5, 7, 2}; xpost0 = 16'd160; xpost1 = 16'hFFC0;
        do_req(16'd64, 16'd0, 16'd0, acc);
        wait_ov("post_fault_ov_timeout", 60, at, saw);
        chk("post_fault_latency", at - acc, 22);
        next();

        // Stage 1 done in its TO-th wait cycle; stray done[3] during stage 0.
        stub_L = '{3, TO, 1, 1}; xpost0 = 16'h0ABC; xpost1 = 16'h0DEF;
        do_req(16'd1, 16'd2, 16'd3, acc);
        next();
        spur_done = 4'b1000;
        next();
        spur_done = 4'b0000;
        wait_ov("race_ov_timeout", 60, at, saw);
        chk("race_latency", at - acc, 18);
        chk("race_no_fault", saw, 0);
        chk("race_x00", o_x00, 16'h0ABC);
        next();

        // Reset while waiting on stage 2.
        stub_L = '{1, 1, 0, 1};
        do_req(16'd9, 16'd9, 16'd9, acc);
        repeat (6) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_x00", o_x00, 0);
        chk("rst_u00", o_u00, 0);
        chk("rst_ready", o_req_ready, 1);
        next();

        // init and request together: state loads, no step begins.
        init = 1'b1; x0_init = 16'h0123; x1_init = 16'hFEDC;
        req_valid = 1'b1; u0 = 16'h0007;
        next();
        init = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("coll_busy", o_busy, 0);
        chk("coll_x00", o_x00, 16'h0123);
        chk("coll_x10", o_x10, 16'hFEDC);
        chk("coll_u00", o_u00, 0);
        repeat (3) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
